// File: rtl/avalon_led_pwm.sv
// avalon_led_pwm: Avalon-MM LED controller, per channel off/on/PWM/blink.
// Build option LED_PWM_IRQ_EN adds STATUS.BLINK_EVT, CTRL.IRQ_EN and irq.
module avalon_led_pwm #(
  parameter int CHANNELS = 8,
  parameter int PWM_W    = 8,
  parameter int PRE_W    = 16,
  parameter int BLINK_W  = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  output logic                irq,
  output logic [CHANNELS-1:0] led_export
);

  localparam logic [PWM_W-1:0] PWM_MAX = '1;

  logic                en, en_nxt, run;
  logic                tick, frame_end, blink_evt;
  logic [PRE_W-1:0]    prescale, pre_cnt;
  logic [BLINK_W-1:0]  blink, blink_cnt;
  logic                blink_phase;
  logic [PWM_W-1:0]    pwm_cnt;
  logic [1:0]          mode     [CHANNELS];
  logic [PWM_W-1:0]    duty     [CHANNELS];
  logic [PWM_W-1:0]    duty_nxt [CHANNELS];
  logic [PWM_W-1:0]    shadow   [CHANNELS];
  logic [CHANNELS-1:0] led_nxt;
  logic [CHANNELS-1:0] wr_ch;
  logic                wr_ctrl, wr_pre, wr_blink;
  logic [31:0]         rd_mux;
  logic                unused_wd;

  assign unused_wd = ^avs_writedata;

  always_comb begin
    wr_ctrl  = avs_write && (avs_address == ADDR_W'(0));
    wr_pre   = avs_write && (avs_address == ADDR_W'(1));
    wr_blink = avs_write && (avs_address == ADDR_W'(2));
    for (int i = 0; i < CHANNELS; i++) begin
      wr_ch[i] = avs_write && (avs_address == ADDR_W'(4 + i));
      duty_nxt[i] = wr_ch[i] ? avs_writedata[PWM_W+1:2] : duty[i];
    end
  end

  // Counters run only when enabled both before and after this edge
  assign en_nxt    = wr_ctrl ? avs_writedata[0] : en;
  assign run       = en && en_nxt;
  assign tick      = run && (pre_cnt == prescale);
  assign frame_end = tick && (pwm_cnt == PWM_MAX);
  assign blink_evt = frame_end && (blink_cnt >= blink);

  always_comb begin
    led_nxt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (mode[i])
        2'd0:    led_nxt[i] = 1'b0;
        2'd1:    led_nxt[i] = 1'b1;
        2'd2:    led_nxt[i] = pwm_cnt < shadow[i];
        default: led_nxt[i] = blink_phase;
      endcase
    end
  end

`ifdef LED_PWM_IRQ_EN
  logic irq_en, evt_flag, wr_stat;

  assign wr_stat = avs_write && (avs_address == ADDR_W'(3));

  // A blink event wins over a same-cycle W1C
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      irq_en   <= 1'b0;
      evt_flag <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en <= avs_writedata[1];
      if (blink_evt) evt_flag <= 1'b1;
      else if (wr_stat && avs_writedata[0]) evt_flag <= 1'b0;
      irq <= evt_flag && irq_en;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    if (avs_address == ADDR_W'(0)) begin
      rd_mux[0] = en;
`ifdef LED_PWM_IRQ_EN
      rd_mux[1] = irq_en;
`endif
    end else if (avs_address == ADDR_W'(1)) begin
      rd_mux[PRE_W-1:0] = prescale;
    end else if (avs_address == ADDR_W'(2)) begin
      rd_mux[BLINK_W-1:0] = blink;
    end else if (avs_address == ADDR_W'(3)) begin
`ifdef LED_PWM_IRQ_EN
      rd_mux[0] = evt_flag;
`endif
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (avs_address == ADDR_W'(4 + i)) begin
        rd_mux[1:0]       = mode[i];
        rd_mux[PWM_W+1:2] = duty[i];
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      en           <= 1'b0;
      prescale     <= '0;
      blink        <= '0;
      pre_cnt      <= '0;
      pwm_cnt      <= '0;
      blink_cnt    <= '0;
      blink_phase  <= 1'b0;
      led_export   <= '0;
      avs_readdata <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        mode[i]   <= '0;
        duty[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      en <= en_nxt;
      if (wr_pre)   prescale <= avs_writedata[PRE_W-1:0];
      if (wr_blink) blink    <= avs_writedata[BLINK_W-1:0];
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_ch[i]) mode[i] <= avs_writedata[1:0];
        duty[i] <= duty_nxt[i];
        if (!run || frame_end) shadow[i] <= duty_nxt[i];
      end
      if (!run || pre_cnt >= prescale) pre_cnt <= '0;
      else pre_cnt <= pre_cnt + PRE_W'(1);
      if (!run) pwm_cnt <= '0;
      else if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (!run) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_evt) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else if (frame_end) begin
        blink_cnt <= blink_cnt + BLINK_W'(1);
      end
      led_export <= run ? led_nxt : '0;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_avalon_led_pwm.sv
// tb_avalon_led_pwm: directed stimulus, arithmetic reference model
// checked every cycle, plus literal waveform expectations.
module tb_avalon_led_pwm;

`ifdef LED_PWM_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  av_addr = '0;
  logic        av_wr = 1'b0;
  logic        av_rd = 1'b0;
  logic [31:0] av_wd = '0;
  logic [31:0] av_rdata;
  logic        irq;
  logic [7:0]  led;

  int checks = 0;
  int errors = 0;

  avalon_led_pwm #(
    .CHANNELS(8), .PWM_W(8), .PRE_W(16),
    .BLINK_W(8), .ADDR_W(4)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(rst_n),
    .avs_address(av_addr),
    .avs_write(av_wr),
    .avs_writedata(av_wd),
    .avs_read(av_rd),
    .avs_readdata(av_rdata),
    .irq(irq),
    .led_export(led)
  );

  always #5 clk = ~clk;

  // Reference model: counter state derived from elapsed run cycles
  int m_en = 0, m_ie = 0, m_pre = 0, m_blk = 0, m_st = 0;
  int m_mode [8];
  int m_duty [8];
  int m_sh   [8];
  int age = 0;
  logic [7:0]  e_led = '0;
  logic [31:0] e_rd = '0;
  logic        e_irq = 1'b0;

  function automatic logic [31:0] mread(input int a);
    if (a == 0) return 32'(m_en | (m_ie << 1));
    if (a == 1) return 32'(m_pre);
    if (a == 2) return 32'(m_blk);
    if (a == 3) return 32'(m_st);
    if (a >= 4 && a < 12) return 32'(m_mode[a-4] | (m_duty[a-4] << 2));
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    int nen, tk, fr, nfr, ph, a;
    bit run, fchg, evt;
    if (!rst_n) begin
      m_en = 0; m_ie = 0; m_pre = 0; m_blk = 0; m_st = 0;
      for (int i = 0; i < 8; i++) begin
        m_mode[i] = 0; m_duty[i] = 0; m_sh[i] = 0;
      end
      age = 0; e_led = '0; e_rd = '0; e_irq = 1'b0;
    end else begin
      a = int'(av_addr);
      if (av_rd) e_rd = mread(a);
      e_irq = (m_st != 0) && (m_ie != 0);
      nen = (av_wr && a == 0) ? int'(av_wd[0]) : m_en;
      run = (m_en != 0) && (nen != 0);
      evt = 1'b0;
      fchg = 1'b0;
      if (run) begin
        tk = age / (m_pre + 1);
        fr = tk / 256;
        ph = (fr / (m_blk + 1)) % 2;
        for (int i = 0; i < 8; i++)
          e_led[i] = (m_mode[i] == 1)
                  || (m_mode[i] == 2 && (tk % 256) < m_sh[i])
                  || (m_mode[i] == 3 && ph == 1);
        age++;
        nfr = (age / (m_pre + 1)) / 256;
        fchg = (nfr != fr);
        evt = fchg && ((nfr % (m_blk + 1)) == 0);
      end else begin
        e_led = '0;
        age = 0;
      end
      if (av_wr) begin
        if (a == 0) begin
          m_en = int'(av_wd[0]);
          if (IRQ_ON) m_ie = int'(av_wd[1]);
        end else if (a == 1) m_pre = int'(av_wd[15:0]);
        else if (a == 2) m_blk = int'(av_wd[7:0]);
        else if (a == 3) begin
          if (av_wd[0]) m_st = 0;
        end else if (a >= 4 && a < 12) begin
          m_mode[a-4] = int'(av_wd[1:0]);
          m_duty[a-4] = int'(av_wd[9:2]);
        end
      end
      if (!run || fchg)
        for (int i = 0; i < 8; i++) m_sh[i] = m_duty[i];
      if (IRQ_ON && evt) m_st = 1;
    end
  end

  always @(posedge clk) begin
    #1;
    checks++;
    if (led !== e_led || av_rdata !== e_rd || irq !== e_irq) begin
      errors++;
      $display("FAIL model t=%0t led=%h/%h rd=%h/%h irq=%b/%b",
               $time, led, e_led, av_rdata, e_rd, irq, e_irq);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wr_reg(input int a, input logic [31:0] d);
    @(negedge clk);
    av_addr = 4'(a); av_wd = d; av_wr = 1'b1;
    @(negedge clk);
    av_wr = 1'b0;
  endtask

  task automatic rd_reg(input int a, output logic [31:0] v);
    @(negedge clk);
    av_addr = 4'(a); av_rd = 1'b1;
    @(negedge clk);
    av_rd = 1'b0;
    v = av_rdata;
  endtask

  task automatic rw_reg(input int a, input logic [31:0] d,
                        output logic [31:0] v);
    @(negedge clk);
    av_addr = 4'(a); av_wd = d; av_wr = 1'b1; av_rd = 1'b1;
    @(negedge clk);
    av_wr = 1'b0; av_rd = 1'b0;
    v = av_rdata;
  endtask

  logic [7:0] rl [1200];
  logic       ri [1200];

  // Sample n is taken in the n-th cycle after the enable edge
  task automatic rec_run(input int len, input int wat,
                         input int wa, input logic [31:0] wdat);
    for (int n = 0; n < len; n++) begin
      if (n > 0) @(negedge clk);
      rl[n] = led;
      ri[n] = irq;
      if (n == wat) begin
        av_addr = 4'(wa); av_wd = wdat; av_wr = 1'b1;
      end else if (n == wat + 1) begin
        av_wr = 1'b0;
      end
    end
  endtask

  function automatic int cnt(input int ch, input int a, input int b);
    int s = 0;
    for (int n = a; n < b; n++) s += int'(rl[n][ch]);
    return s;
  endfunction

  function automatic int rises(input int ch, input int a, input int b);
    int s = 0;
    for (int n = a + 1; n < b; n++)
      if (rl[n][ch] && !rl[n-1][ch]) s++;
    return s;
  endfunction

  initial begin
    logic [31:0] v;
    int ion;
    ion = IRQ_ON ? 1 : 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_led", int'(led), 0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_rdata", int'(av_rdata), 0);
    for (int a = 0; a < 12; a++) begin
      rd_reg(a, v);
      chk($sformatf("rst_read%0d", a), int'(v), 0);
    end

    wr_reg(1, 0);
    wr_reg(2, 1);
    wr_reg(4, (64 << 2) | 2);
    wr_reg(5, 3);
    wr_reg(6, 1);
    wr_reg(7, 2);
    wr_reg(8, (255 << 2) | 2);
    wr_reg(0, 1);
    rec_run(1100, 612, 4, (200 << 2) | 2);
    chk("pwm_c0", int'(rl[0][0]), 0);
    chk("pwm_c1", int'(rl[1][0]), 1);
    chk("pwm_c64", int'(rl[64][0]), 1);
    chk("pwm_c65", int'(rl[65][0]), 0);
    chk("pwm_hi_f0", cnt(0, 0, 256), 64);
    chk("pwm_rise_f1", int'(rl[257][0]), 1);
    chk("duty_keep", cnt(0, 512, 768), 64);
    chk("duty_new", cnt(0, 768, 1024), 200);
    chk("no_glitch", rises(0, 512, 1024), 2);
    chk("blink_512", int'(rl[512][1]), 0);
    chk("blink_513", int'(rl[513][1]), 1);
    chk("blink_1024", int'(rl[1024][1]), 1);
    chk("blink_1025", int'(rl[1025][1]), 0);
    chk("on_c0", int'(rl[0][2]), 0);
    chk("on_c1", int'(rl[1][2]), 1);
    chk("duty0", cnt(3, 0, 1100), 0);
    chk("dutymax", cnt(4, 256, 512), 255);

    wr_reg(0, 0);
    chk("dis_led", int'(led), 0);
    rw_reg(3, 1, v);
    chk("stat_same", int'(v), ion);
    rd_reg(3, v);
    chk("stat_after", int'(v), 0);
    rw_reg(6, (10 << 2) | 2, v);
    chk("ch2_same", int'(v), 1);
    rd_reg(6, v);
    chk("ch2_after", int'(v), 42);
    wr_reg(15, 32'hFFFF_FFFF);
    rd_reg(15, v);
    chk("unmapped", int'(v), 0);

    wr_reg(1, 1);
    wr_reg(0, 1);
    rec_run(520, -1, 0, 0);
    chk("pre1_cnt", cnt(0, 0, 512), 400);
    chk("pre1_400", int'(rl[400][0]), 1);
    chk("pre1_401", int'(rl[401][0]), 0);
    chk("pre1_ch2", cnt(2, 0, 512), 20);
    chk("pre1_max", cnt(4, 0, 512), 510);

    wr_reg(0, 0);
    wr_reg(1, 0);
    wr_reg(2, 0);
    wr_reg(3, 1);
    wr_reg(0, 3);
    rec_run(600, 300, 3, 1);
    chk("irq_256", int'(ri[256]), 0);
    chk("irq_257", int'(ri[257]), ion);
    chk("irq_301", int'(ri[301]), ion);
    chk("irq_302", int'(ri[302]), 0);
    chk("irq_512", int'(ri[512]), 0);
    chk("irq_513", int'(ri[513]), ion);
    chk("blk0_256", int'(rl[256][1]), 0);
    chk("blk0_257", int'(rl[257][1]), 1);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_led", int'(led), 0);
    chk("mrst_irq", int'(irq), 0);
    chk("mrst_rdata", int'(av_rdata), 0);
    rd_reg(4, v);
    chk("mrst_ch0", int'(v), 0);
    wr_reg(4, (64 << 2) | 2);
    wr_reg(0, 1);
    rec_run(300, -1, 0, 0);
    chk("mrst_c1", int'(rl[1][0]), 1);
    chk("mrst_c64", int'(rl[64][0]), 1);
    chk("mrst_c65", int'(rl[65][0]), 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
